// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, reset defaults, opcode encodings
// and the fetch FSM state type.
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    localparam logic [6:0] OP_IMM = 7'd19;
    localparam logic [6:0] STORE  = 7'd35;
    localparam logic [6:0] JAL    = 7'd111;
    localparam logic [6:0] LOAD   = 7'd3;
    localparam logic [6:0] BRANCH = 7'd99;
    localparam logic [6:0] LUI    = 7'd55;
    localparam logic [6:0] OP     = 7'd51;

    // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {instr, pc} pairs between instruction
// memory and decode; synchronous flush, asynchronous reset.
module fetch_fifo #(
    parameter int          DEPTH     = 2,
    parameter int          XLEN      = riscv_pkg::XLEN,
    parameter logic [31:0] RST_INSTR = riscv_pkg::NOP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [31:0]              push_instr,
    input  logic [XLEN-1:0]          push_pc,
    input  logic                     pop,
    input  logic                     flush,
    output logic [31:0]              head_instr,
    output logic [XLEN-1:0]          head_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    // Flush beats both push and pop; popping an empty buffer is ignored.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is reset only because the head must read as a NOP at pc 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= RST_INSTR;
                pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                instr_mem[wr_ptr] <= push_instr;
                pc_mem[wr_ptr]    <= push_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one memory read in
// flight, buffers returned words and hands them to decode with valid/ready.
module instr_fetch #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEF,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode
);

    import riscv_pkg::*;

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] redirect_aligned;
    logic [CW-1:0]   count;
    logic            issue;
    logic            push;
    logic            pop;

    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // Issuing only from IDLE means an outstanding request already owns a buffer slot.
    assign issue = !rst && (state == IDLE) && (count < FULL) && !redirect_valid;

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign opcode      = instr[6:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (issue) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push      = !redirect_valid;
                    state_nxt = IDLE;
                end else if (redirect_valid) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc <= redirect_aligned;
            end else if (issue) begin
                pc     <= pc + XLEN'(4);
                req_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .XLEN      (XLEN),
        .RST_INSTR (NOP)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (req_pc),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .count      (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model answers requests, directed
// phases queue the instructions decode must see, a monitor compares deliveries.
module tb_instr_fetch;

    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [6:0]  op;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    int          total = 0;
    int          bad   = 0;
    int          n_deq = 0;
    int          lat   = 1;
    bit          ready_en = 1'b0;
    bit          manual   = 1'b0;

    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr = '0;

    instr_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] opc;
        case (a[4:2])
            3'd0:    opc = OP_IMM;
            3'd1:    opc = STORE;
            3'd2:    opc = JAL;
            3'd3:    opc = LOAD;
            3'd4:    opc = BRANCH;
            3'd5:    opc = LUI;
            3'd6:    opc = OP;
            default: opc = OP_IMM;
        endcase
        if (a == 32'h0) return 32'h0050_0093;
        return {a[26:2], opc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [6:0] op);
        exp_t e;
        e.instr = mem_word(pc);
        e.pc    = pc;
        e.op    = op;
        exp_q.push_back(e);
    endtask

    // One cycle: inputs change at the falling edge, away from the DUT's sampling edge.
    task automatic step();
        @(negedge clk);
        redirect_valid = 1'b0;
        if (!manual) instr_ready = ready_en && (exp_q.size() != 0);
    endtask

    task automatic do_reset(input int l);
        step();
        rst = 1'b1;
        lat = l;
        repeat (3) step();
        exp_q.delete();
        req_log.delete();
        n_deq = 0;
        rst   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    imem_req, 0);
        check({tag, "_addr"},   imem_addr, 32'h0);
        check({tag, "_valid"},  instr_valid, 0);
        check({tag, "_instr"},  instr, 32'h0000_0013);
        check({tag, "_pc"},     instr_pc, 32'h0);
        check({tag, "_opcode"}, {25'b0, opcode}, 32'd19);
    endtask

    // Memory model: response arrives 'lat' cycles after the request cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end
            end
            if (imem_req) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_addr;
                req_log.push_back(imem_addr);
            end
        end
    end

    // Monitor: a transfer happens on the next rising edge when valid && ready without redirect.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && instr_valid && instr_ready && !redirect_valid) begin
                n_deq++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", instr, e.instr);
                    check("instr_pc", instr_pc, e.pc);
                    check("opcode", {25'b0, opcode}, {25'b0, e.op});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) step();
        #3;
        check_reset_outputs("reset");

        // Sequential fetch with 1-cycle memory.
        do_reset(1);
        #3;
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 32'h0);
        ready_en = 1'b1;
        push_exp(32'h0, 7'd19);
        push_exp(32'h4, 7'd35);
        push_exp(32'h8, 7'd111);
        drain("seq_drain");
        check("seq_req0", req_log[0], 32'h0);
        check("seq_req1", req_log[1], 32'h4);
        check("seq_req2", req_log[2], 32'h8);

        // Decoder stalled: buffer fills, fetch stops, nothing lost on release.
        ready_en = 1'b0;
        do_reset(1);
        repeat (10) step();
        #3;
        check("stall_nreq", req_log.size(), 2);
        check("stall_req", imem_req, 0);
        check("stall_valid", instr_valid, 1);
        push_exp(32'h0, 7'd19);
        push_exp(32'h4, 7'd35);
        push_exp(32'h8, 7'd111);
        ready_en = 1'b1;
        drain("stall_drain");

        // Redirect with a full buffer, unaligned target.
        ready_en = 1'b0;
        do_reset(1);
        repeat (10) step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #3;
        check("redir_noreq", imem_req, 0);
        step();
        #3;
        check("redir_req", imem_req, 1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("redir_flushed", instr_valid, 0);
        push_exp(32'h100, 7'd19);
        push_exp(32'h104, 7'd35);
        ready_en = 1'b1;
        drain("redir_drain");

        // 3-cycle memory, redirect while a kept response is outstanding.
        ready_en = 1'b0;
        do_reset(3);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        #3;
        check("drop_noreq_c", imem_req, 0);
        step();
        #3;
        check("drop_noreq_d", imem_req, 0);
        step();
        #3;
        check("drop_req", imem_req, 1);
        check("drop_addr", imem_addr, 32'h0000_0200);
        check("drop_empty", instr_valid, 0);
        push_exp(32'h200, 7'd19);
        push_exp(32'h204, 7'd35);
        ready_en = 1'b1;
        drain("drop_drain");

        // Redirect coincident with a response and a pop.
        ready_en    = 1'b0;
        manual      = 1'b1;
        instr_ready = 1'b0;
        do_reset(1);
        step();
        step();
        #3;
        check("coin_addr4", imem_addr, 32'h4);
        step();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        #3;
        check("coin_valid", instr_valid, 1);
        check("coin_rvalid", imem_rvalid, 1);
        step();
        instr_ready = 1'b0;
        #3;
        check("coin_flush", instr_valid, 0);
        check("coin_addr", imem_addr, 32'h0000_0300);
        check("coin_ndeq", n_deq, 0);
        manual = 1'b0;
        push_exp(32'h300, 7'd19);
        push_exp(32'h304, 7'd35);
        ready_en = 1'b1;
        drain("coin_drain");

        // Wrap at the top of the address space, then reset mid-WAIT.
        ready_en = 1'b1;
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC, 7'd19);
        step();
        #3;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        #3;
        check("wrap_next", imem_addr, 32'h0);
        check("wrap_next_req", imem_req, 1);
        step();
        rst = 1'b1;
        #3;
        check_reset_outputs("midrst");
        check("wrap_log0", req_log[0], 32'hFFFF_FFFC);
        check("wrap_log1", req_log[1], 32'h0);
        check("wrap_delivered", exp_q.size(), 0);
        repeat (3) step();
        rst = 1'b0;
        #3;
        check("post_rst_req", imem_req, 1);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_valid", instr_valid, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the RISC-V core: owns the program counter, issues word reads to instruction memory, buffers returned instructions in a small FIFO and presents them with a valid/ready handshake to the decode side, where `opcode` feeds the control unit (`UC`). Branch and jump outcomes from execute redirect the PC, flushing buffered and in-flight instructions. It sits between instruction memory and the decoder.

## Interface
Parameters:
- `XLEN`, 32, address/data width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, instruction buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `imem_req`  out  1  read request; memory accepts every cycle it is high
- `imem_addr`  out  XLEN  word address of request, bits [1:0] always 0
- `imem_rvalid`  in  1  response valid, in order, ≥1 cycle after request
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  taken branch/jump/jal from execute
- `redirect_pc`  in  XLEN  target; bits [1:0] forced to 0 internally
- `instr_valid`  out  1  buffer head valid
- `instr_ready`  in  1  decoder consumes head when valid&&ready
- `instr`  out  32  head instruction
- `instr_pc`  out  XLEN  address of head instruction
- `opcode`  out  7  `instr[6:0]`, direct to `UC`

## Operation
- FSM states: IDLE (nothing outstanding), WAIT (one request outstanding, response kept), DROP (one outstanding, response discarded). At most one request in flight.
- Issue condition: state==IDLE and `count` < DEPTH. On issue: `imem_req`=1, `imem_addr`=`pc`, `req_pc`<=`pc`, `pc`<=`pc`+4 (mod 2^XLEN, wraps FFFF_FFFC→0000_0000), IDLE→WAIT.
- WAIT & `imem_rvalid`: push {`imem_rdata`,`req_pc`} into FIFO, →IDLE.
- DROP & `imem_rvalid`: discard, →IDLE.
- Redirect (highest priority): FIFO flushed (count←0), `pc`←`redirect_pc`&~3; WAIT→DROP (or →IDLE if `imem_rvalid` same cycle, response discarded); DROP stays DROP unless `imem_rvalid` same cycle →IDLE; IDLE stays IDLE, no issue that cycle.
- Simultaneous push and pop: both occur, count unchanged. Pop on same cycle as redirect: ignored (flush wins).
- Full: no issue while count==DEPTH; slot reserved by outstanding request counts as used (issue only if count+(state!=IDLE) < DEPTH, i.e. IDLE and count<DEPTH).
- Empty: `instr_valid`=0, `instr`/`instr_pc` hold last head contents (don't care).
- `imem_rvalid` in IDLE is a protocol error: ignored.

## Timing
- Reset values: `pc`=RESET_PC, state=IDLE, count=0, `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=0, `opcode`=7'd19.
- `imem_req`/`imem_addr` combinational from registered state, count and `redirect_valid`; first request in first cycle after `rst` falls.
- Push occurs on the `imem_rvalid` edge; `instr_valid` high the following cycle (no bypass).
- With 1-cycle memory: redirect in cycle N → request at `redirect_pc` in N+1 → rvalid N+2 → `instr_valid` N+3. If redirect hits WAIT, add one cycle per remaining memory latency.
- Steady-state throughput with 1-cycle memory: one instruction per 2 cycles.
- Reset mid-operation: all state returns to reset values immediately; a late `imem_rvalid` after reset is ignored (state IDLE).

## Structure
- Shared package `riscv_pkg`: XLEN, RESET_PC default, NOP encoding 32'h0000_0013, opcode constants (OP_IMM 7'd19, STORE 7'd35, JAL 7'd111, LOAD 7'd3, BRANCH 7'd99, LUI 7'd55, OP 7'd51), fetch FSM state encoding.
- One sub-module: `fetch_fifo` (DEPTH-entry, {instr,pc} payload, push/pop/flush, count, synchronous flush, async reset).

## Test plan
- Reset release, 1-cycle memory returning `imem_addr`-indexed words, `instr_ready`=1 → requests at 0,4,8,…; `instr_pc` sequence 0,4,8; `opcode` 19 for word 32'h00500093.
- `instr_ready`=0 for 10 cycles → exactly DEPTH=2 requests issued then `imem_req` stays 0; release → head pc 0 then 4, no loss.
- Redirect to 32'h0000_0103 while FIFO holds 2 entries → flush, next `imem_addr`=32'h0000_0100, next `instr_pc`=0x100.
- 3-cycle memory, redirect while WAIT → state DROP, returned word never appears on `instr`; following fetch from target.
- Redirect coincident with `imem_rvalid` and with pop → response dropped, count 0, no dequeue counted.
- Redirect to 32'hFFFF_FFFC → fetches FFFF_FFFC then 0000_0000; assert `rst` mid-WAIT → all outputs at reset values, next request at RESET_PC.
